// File: rtl/plot_arbiter.sv
// plot_arbiter: grants one of four pixel sources exclusive access to the
// framebuffer write port and forwards the owner's pixels with one cycle of
// latency.
//   clk, resetn    clock; synchronous active-low reset
//   req[3:0]       per-requester request (0 painter, 1 player, 2 aliens, 3 bullets)
//   pix_valid[3:0] requester i presents a pixel this cycle
//   req_done[3:0]  requester i's current pixel is its last
//   x_in/y_in/col_in  packed per-requester pixel fields (9/8/3 bits each)
//   gnt[3:0]       one-hot grant or zero
//   vga_x/vga_y/vga_colour/vga_plot  framebuffer write port
//   busy           state is not IDLE
//   timeout_err    sticky: an owner was force-released by the watchdog
module plot_arbiter #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned X_MAX   = 319,
    parameter int unsigned Y_MAX   = 239
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [3:0]  pix_valid,
    input  logic [3:0]  req_done,
    input  logic [35:0] x_in,
    input  logic [31:0] y_in,
    input  logic [11:0] col_in,
    output logic [3:0]  gnt,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [8:0] XM = 9'(X_MAX);
    localparam logic [7:0] YM = 8'(Y_MAX);

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t         state, state_n;
    logic [1:0]     owner, owner_n;
    logic [1:0]     rr, rr_n;          // last winner among requesters 1..3
    logic [WDW-1:0] wd, wd_n;
    logic [3:0]     gnt_n;
    logic [8:0]     vga_x_n;
    logic [7:0]     vga_y_n;
    logic [2:0]     vga_colour_n;
    logic           vga_plot_n, busy_n, timeout_err_n;

    logic [8:0] xs [4];
    logic [7:0] ys [4];
    logic [2:0] cs [4];
    logic [1:0] rr_pick;
    logic       rr_found;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            xs[i] = x_in[9*i +: 9];
            ys[i] = y_in[8*i +: 8];
            cs[i] = col_in[3*i +: 3];
        end
    end

    // Round-robin among 1..3, starting at the index after the last winner.
    always_comb begin
        rr_pick  = 2'd1;
        rr_found = 1'b0;
        for (int unsigned k = 1; k <= 3; k++) begin
            int unsigned idx;
            idx = ((32'(rr) + k - 1) % 3) + 1;
            if (!rr_found && req[idx]) begin
                rr_pick  = 2'(idx);
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n       = state;
        owner_n       = owner;
        rr_n          = rr;
        wd_n          = wd;
        gnt_n         = gnt;
        vga_x_n       = vga_x;
        vga_y_n       = vga_y;
        vga_colour_n  = vga_colour;
        vga_plot_n    = 1'b0;
        timeout_err_n = timeout_err;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (|req) begin
                    state_n = OWN;
                    wd_n    = '0;
                    if (req[0]) begin
                        owner_n = 2'd0;
                        gnt_n   = 4'b0001;
                    end else begin
                        owner_n = rr_pick;
                        rr_n    = rr_pick;
                        gnt_n   = 4'b0001 << rr_pick;
                    end
                end
            end
            OWN: begin
                // Dropped request wins over any pixel offered in the same cycle.
                if (!req[owner]) begin
                    state_n = GAP;
                    gnt_n   = '0;
                end else if (pix_valid[owner]) begin
                    wd_n = '0;
                    if (xs[owner] <= XM && ys[owner] <= YM) begin
                        vga_plot_n   = 1'b1;
                        vga_x_n      = xs[owner];
                        vga_y_n      = ys[owner];
                        vga_colour_n = cs[owner];
                    end
                    if (req_done[owner]) begin
                        state_n = GAP;
                        gnt_n   = '0;
                    end
                end else if (wd == WD_LAST) begin
                    state_n       = GAP;
                    gnt_n         = '0;
                    timeout_err_n = 1'b1;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end
            GAP: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            owner       <= 2'd0;
            rr          <= 2'd3;
            wd          <= '0;
            gnt         <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            owner       <= owner_n;
            rr          <= rr_n;
            wd          <= wd_n;
            gnt         <= gnt_n;
            vga_x       <= vga_x_n;
            vga_y       <= vga_y_n;
            vga_colour  <= vga_colour_n;
            vga_plot    <= vga_plot_n;
            busy        <= busy_n;
            timeout_err <= timeout_err_n;
        end
    end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter (TIMEOUT overridden to 16).
module tb_plot_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req, pix_valid, req_done;
    logic [35:0] x_in;
    logic [31:0] y_in;
    logic [11:0] col_in;
    logic [3:0]  gnt;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot, busy, timeout_err;

    int errors = 0;
    int checks = 0;

    plot_arbiter #(.TIMEOUT(16), .X_MAX(319), .Y_MAX(239)) dut (
        .clk(clk), .resetn(resetn), .req(req), .pix_valid(pix_valid),
        .req_done(req_done), .x_in(x_in), .y_in(y_in), .col_in(col_in),
        .gnt(gnt), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int i, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
        x_in[9*i +: 9]   = x;
        y_in[8*i +: 8]   = y;
        col_in[3*i +: 3] = c;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = '0; pix_valid = '0; req_done = '0;
        x_in = '0; y_in = '0; col_in = '0;
        tick(); tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (vga_plot !== 1'b0) begin errors++; $display("FAIL reset_plot got=%b exp=0", vga_plot); end
        checks++; if ({vga_x, vga_y, vga_colour} !== 20'd0) begin errors++; $display("FAIL reset_xyc got=%0d,%0d,%0d exp=0,0,0", vga_x, vga_y, vga_colour); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", timeout_err); end
        resetn = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL idle_noreq gnt=%b busy=%b exp=0000,0", gnt, busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [3];
        exp_g[0] = 4'b0100; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010;
        req = 4'b1110;
        tick();
        checks++; if (gnt !== 4'b0010 || busy !== 1'b1) begin errors++; $display("FAIL rr_first gnt=%b busy=%b exp=0010,1", gnt, busy); end
        for (int k = 0; k < 3; k++) begin
            set_pix(k + 1, 9'(10 + k), 8'(20 + k), 3'(k + 1));
            pix_valid = 4'b0001 << (k + 1);
            req_done  = 4'b0001 << (k + 1);
            tick();
            checks++;
            if (vga_plot !== 1'b1 || vga_x !== 9'(10 + k) || vga_y !== 8'(20 + k) || vga_colour !== 3'(k + 1) || gnt !== 4'b0000) begin
                errors++; $display("FAIL rr_done%0d plot=%b xyc=%0d,%0d,%0d gnt=%b exp=1 %0d,%0d,%0d 0000", k, vga_plot, vga_x, vga_y, vga_colour, gnt, 10 + k, 20 + k, k + 1);
            end
            pix_valid = '0; req_done = '0;
            tick();
            checks++; if (gnt !== 4'b0000 || vga_plot !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rr_gap%0d gnt=%b plot=%b busy=%b exp=0000,0,0", k, gnt, vga_plot, busy); end
            tick();
            checks++; if (gnt !== exp_g[k]) begin errors++; $display("FAIL rr_next%0d gnt=%b exp=%b", k, gnt, exp_g[k]); end
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_painter();
        int bad = 0;
        logic last;
        req = 4'b0011;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL paint_grant gnt=%b exp=0001", gnt); end
        for (int yy = 0; yy < 240; yy++) begin
            for (int xx = 0; xx < 320; xx++) begin
                last = (xx == 319 && yy == 239);
                set_pix(0, xx[8:0], yy[7:0], 3'((xx + yy) % 8));
                set_pix(1, 9'd1, 8'd1, 3'd7);
                pix_valid = 4'b0011;
                req_done  = last ? 4'b0011 : 4'b0010;
                tick();
                if (vga_plot !== 1'b1 || vga_x !== xx[8:0] || vga_y !== yy[7:0] ||
                    vga_colour !== 3'((xx + yy) % 8) || gnt !== (last ? 4'b0000 : 4'b0001))
                    bad++;
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL paint_stream bad_pixels=%0d exp=0", bad); end
        checks++; if (vga_x !== 9'd319 || vga_y !== 8'd239 || vga_plot !== 1'b1) begin errors++; $display("FAIL paint_last xy=%0d,%0d plot=%b exp=319,239,1", vga_x, vga_y, vga_plot); end
        req = 4'b0010; pix_valid = '0; req_done = '0;
        tick();
        checks++; if (gnt !== 4'b0000 || vga_plot !== 1'b0) begin errors++; $display("FAIL paint_gap gnt=%b plot=%b exp=0000,0", gnt, vga_plot); end
        tick();
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL paint_then1 gnt=%b exp=0010", gnt); end
        // Owner drops req while offering a pixel: released, pixel not written.
        req = '0; set_pix(1, 9'd3, 8'd3, 3'd3); pix_valid = 4'b0010;
        tick();
        checks++; if (gnt !== 4'b0000 || vga_plot !== 1'b0 || vga_x !== 9'd319) begin errors++; $display("FAIL reqfall gnt=%b plot=%b x=%0d exp=0000,0,319", gnt, vga_plot, vga_x); end
        pix_valid = '0;
        tick(); tick();
    endtask

    task automatic test_drop();
        req = 4'b0100;
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL drop_grant gnt=%b exp=0100", gnt); end
        // Painter requests and offers a pixel too: no preemption, ignored.
        req = 4'b0101; pix_valid = 4'b0101;
        set_pix(0, 9'd1, 8'd1, 3'd1);
        set_pix(2, 9'd10, 8'd20, 3'd5);
        tick();
        checks++; if (vga_plot !== 1'b1 || vga_x !== 9'd10 || vga_y !== 8'd20 || vga_colour !== 3'd5 || gnt !== 4'b0100) begin
            errors++; $display("FAIL drop_p1 plot=%b xyc=%0d,%0d,%0d gnt=%b exp=1 10,20,5 0100", vga_plot, vga_x, vga_y, vga_colour, gnt);
        end
        req = 4'b0100; pix_valid = 4'b0100; req_done = 4'b0100;
        set_pix(2, 9'd400, 8'd5, 3'd1);
        tick();
        checks++; if (vga_plot !== 1'b0 || vga_x !== 9'd10 || gnt !== 4'b0000 || busy !== 1'b1) begin
            errors++; $display("FAIL drop_p2 plot=%b x=%0d gnt=%b busy=%b exp=0,10,0000,1", vga_plot, vga_x, gnt, busy);
        end
        req = '0; pix_valid = '0; req_done = '0;
        tick();
        checks++; if (busy !== 1'b0 || gnt !== 4'b0000 || vga_plot !== 1'b0) begin errors++; $display("FAIL drop_idle busy=%b gnt=%b plot=%b exp=0,0000,0", busy, gnt, vga_plot); end
    endtask

    task automatic test_timeout();
        int bad = 0;
        req = 4'b1000;
        tick();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL to_grant gnt=%b exp=1000", gnt); end
        req_done = 4'b1000;   // done without pixel is ignored
        for (int i = 1; i < 16; i++) begin
            tick();
            if (gnt !== 4'b1000 || timeout_err !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL to_hold bad_cycles=%0d exp=0", bad); end
        tick();
        checks++; if (gnt !== 4'b0000 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_release gnt=%b err=%b exp=0000,1", gnt, timeout_err); end
        req = '0; req_done = '0;
        tick(); tick(); tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky err=%b exp=1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        req = 4'b1110;
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rm_grant gnt=%b exp=0010", gnt); end
        pix_valid = 4'b0010;
        set_pix(1, 9'd50, 8'd60, 3'd6);
        tick();
        checks++; if (vga_plot !== 1'b1 || vga_x !== 9'd50) begin errors++; $display("FAIL rm_pix plot=%b x=%0d exp=1,50", vga_plot, vga_x); end
        resetn = 1'b0;
        set_pix(1, 9'd7, 8'd8, 3'd2);
        tick();
        checks++; if ({gnt, vga_plot, busy, timeout_err} !== 7'd0 || {vga_x, vga_y, vga_colour} !== 20'd0) begin
            errors++; $display("FAIL rm_reset gnt=%b plot=%b busy=%b err=%b xyc=%0d,%0d,%0d exp=all 0", gnt, vga_plot, busy, timeout_err, vga_x, vga_y, vga_colour);
        end
        resetn = 1'b1; pix_valid = '0;
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rm_rr_restart gnt=%b exp=0010", gnt); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_painter();
        test_drop();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
